// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell processes the operands
// LSB first, one bit per clock, and registers the full difference on completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] differ,
  output logic             barrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             a_bit, b_bit, d_bit, br_next;

  assign accept   = start && (state != SHIFT);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign a_bit    = a_reg[cnt];
  assign b_bit    = b_reg[cnt];
  assign d_bit    = a_bit ^ b_bit ^ br_reg;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Result bits enter at the top and walk down, so bit 0 lands in place after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      br_reg  <= 1'b0;
      cnt     <= '0;
      differ  <= '0;
      barrow  <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      br_reg  <= borrow_in;
      res_reg <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      res_reg <= {d_bit, res_reg[WIDTH-1:1]};
      br_reg  <= br_next;
      if (last_bit) begin
        cnt    <= '0;
        differ <= {d_bit, res_reg[WIDTH-1:1]};
        barrow <= br_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep checks for serial_subtractor at WIDTH=8 and WIDTH=2,
// with expected differences worked out by hand or by plain integer arithmetic.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, borrow_in, busy, done, barrow;
  logic [7:0] a, b, differ;
  logic       start2, bi2, busy2, done2, barrow2;
  logic [1:0] a2, b2, differ2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .differ(differ), .barrow(barrow)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .borrow_in(bi2),
    .busy(busy2), .done(done2), .differ(differ2), .barrow(barrow2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Operands are scrambled right after acceptance; the result must not notice.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic biv);
    int n;
    a = av; b = bv; borrow_in = biv; start = 1'b1;
    tick;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
    n = 0;
    while (!done && n < 12) begin
      tick;
      n++;
    end
    if (!done) checkOutput("done_timeout8", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus2(input logic [1:0] av, input logic [1:0] bv, input logic biv);
    int n;
    a2 = av; b2 = bv; bi2 = biv; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); bi2 = 1'($urandom);
    n = 0;
    while (!done2 && n < 6) begin
      tick;
      n++;
    end
    if (!done2) checkOutput("done_timeout2", 32'd0, 32'd1);
  endtask

  initial begin
    int dones;
    int e;
    logic [7:0] ra, rb;
    logic       rbi;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bi2 = 1'b0;
    tick;
    tick;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_differ", differ, 0);
    checkOutput("rst_barrow", barrow, 0);

    // 5 - 3: exact edge timing; start is taken on the first edge after release
    rst_n = 1'b1;
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("e0_busy", busy, 1);
    checkOutput("e0_done", done, 0);
    for (int i = 1; i < 8; i++) begin
      tick;
      checkOutput("shift_busy", busy, 1);
      checkOutput("shift_done", done, 0);
      checkOutput("shift_differ_held", differ, 0);
    end
    tick;
    checkOutput("e8_done", done, 1);
    checkOutput("e8_busy", busy, 0);
    checkOutput("e8_differ", differ, 8'h02);
    checkOutput("e8_barrow", barrow, 0);
    tick;
    checkOutput("e9_done", done, 0);

    applyStimulus(8'h00, 8'h01, 1'b0);
    checkOutput("0m1_differ", differ, 8'hFF);
    checkOutput("0m1_barrow", barrow, 1);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    checkOutput("ffmff1_differ", differ, 8'hFF);
    checkOutput("ffmff1_barrow", barrow, 1);

    // start during SHIFT must be ignored
    tick;
    a = 8'h10; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 4; i < 8; i++) begin
      tick;
      checkOutput("ign_busy", busy, 1);
    end
    tick;
    checkOutput("ign_done", done, 1);
    checkOutput("ign_differ", differ, 8'h0F);
    checkOutput("ign_barrow", barrow, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (done) dones++;
    end
    checkOutput("ign_no_second", dones, 0);
    checkOutput("ign_idle_busy", busy, 0);

    // back-to-back: start held in the DONE cycle
    applyStimulus(8'h20, 8'h03, 1'b0);
    checkOutput("b2b1_differ", differ, 8'h1D);
    a = 8'h07; b = 8'h09; borrow_in = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("b2b_busy", busy, 1);
    for (int i = 1; i < 8; i++) begin
      tick;
      checkOutput("b2b_held", differ, 8'h1D);
      checkOutput("b2b_done_low", done, 0);
    end
    tick;
    checkOutput("b2b2_done", done, 1);
    checkOutput("b2b2_differ", differ, 8'hFD);
    checkOutput("b2b2_barrow", barrow, 1);

    // reset mid-SHIFT
    tick;
    a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_differ", differ, 0);
    checkOutput("mid_rst_barrow", barrow, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done) dones++;
    end
    checkOutput("mid_rst_no_done", dones, 0);
    rst_n = 1'b1;
    applyStimulus(8'h33, 8'h11, 1'b0);
    checkOutput("post_rst_differ", differ, 8'h22);
    checkOutput("post_rst_barrow", barrow, 0);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          applyStimulus2(2'(x), 2'(y), 1'(c));
          e = x - y - c;
          checkOutput("w2_differ", differ2, e & 3);
          checkOutput("w2_barrow", barrow2, (e < 0) ? 1 : 0);
        end

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      applyStimulus(ra, rb, rbi);
      e = int'(ra) - int'(rb) - int'(rbi);
      checkOutput("rand_differ", differ, e & 255);
      checkOutput("rand_barrow", barrow, (e < 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
